// File: rtl/sha_pkg.sv
// rtl/sha_pkg.sv - shared SHA-256 schedule buffer types and default sizes
package sha_pkg;

  // SHA-256 message schedule defaults
  localparam int WORD_W       = 32;
  localparam int SCHED_DEPTH  = 16;
  localparam int SCHED_SHIFTS = 48;

  // Word buffer control states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_RUN  = 2'd2
  } wbuf_state_t;

endpackage : sha_pkg

// File: rtl/sha_wbuf.sv
// rtl/sha_wbuf.sv - SHA message word shift bank; optional macro SHA_WBUF_CLR_EN zeroes the bank on start
module sha_wbuf
  import sha_pkg::*;
#(
  parameter int WIDTH  = WORD_W,
  parameter int DEPTH  = SCHED_DEPTH,
  parameter int SHIFTS = SCHED_SHIFTS
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         start,
  input  logic                         wr_valid,
  input  logic [WIDTH-1:0]             wr_data,
  output logic                         wr_ready,
  input  logic                         shift_en,
  input  logic [WIDTH-1:0]             sched_in,
  output logic [DEPTH*WIDTH-1:0]       data_o,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         done
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(SHIFTS + 1);

`ifdef SHA_WBUF_CLR_EN
  localparam bit CLR_ON_START = 1'b1;
`else
  localparam bit CLR_ON_START = 1'b0;
`endif

  wbuf_state_t      state;
  logic [SW-1:0]    shift_cnt;
  logic [WIDTH-1:0] entry [DEPTH];

  logic             fill_acc;
  logic             run_acc;
  logic             shift_acc;
  logic [WIDTH-1:0] shift_src;

  // start wins over any simultaneous word or shift request
  assign fill_acc  = (state == ST_FILL) && wr_valid && !start;
  assign run_acc   = (state == ST_RUN) && shift_en && !start;
  assign shift_acc = fill_acc || run_acc;
  assign shift_src = (state == ST_RUN) ? sched_in : wr_data;

  assign wr_ready = (state == ST_FILL);

  // Control FSM: state, word count, shift count and registered status flags
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= ST_IDLE;
      count     <= '0;
      shift_cnt <= '0;
      full      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        state     <= ST_FILL;
        count     <= '0;
        shift_cnt <= '0;
        full      <= 1'b0;
      end else begin
        case (state)
          ST_FILL: begin
            if (wr_valid) begin
              count <= count + CW'(1);
              if (count == CW'(DEPTH - 1)) begin
                state <= ST_RUN;
                full  <= 1'b1;
              end
            end
          end
          ST_RUN: begin
            if (shift_en) begin
              shift_cnt <= shift_cnt + SW'(1);
              if (shift_cnt == SW'(SHIFTS - 1)) begin
                state <= ST_IDLE;
                full  <= 1'b0;
                done  <= 1'b1;
              end
            end
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  // Bank: one register per entry, each takes its younger neighbour on a shift
  for (genvar i = 0; i < DEPTH; i++) begin : g_bank
    if (i == DEPTH - 1) begin : g_tail
      // Tail entry loads the new word from the active shift source
      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          entry[i] <= '0;
        end else if (start && CLR_ON_START) begin
          entry[i] <= '0;
        end else if (shift_acc) begin
          entry[i] <= shift_src;
        end
      end
    end else begin : g_body
      // Body entry moves one step toward the oldest position
      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          entry[i] <= '0;
        end else if (start && CLR_ON_START) begin
          entry[i] <= '0;
        end else if (shift_acc) begin
          entry[i] <= entry[i+1];
        end
      end
    end
    assign data_o[i*WIDTH +: WIDTH] = entry[i];
  end

endmodule : sha_wbuf

// File: tb/tb_sha_wbuf.sv
// tb/tb_sha_wbuf.sv - scoreboard bench for sha_wbuf against a queue-based model
module tb_sha_wbuf;

  localparam int WIDTH  = 32;
  localparam int DEPTH  = 16;
  localparam int SHIFTS = 48;
  localparam int CW     = $clog2(DEPTH + 1);
  localparam int DW     = DEPTH * WIDTH;

  logic             CLK = 1'b0;
  logic             RST = 1'b0;
  logic             start = 1'b0;
  logic             wr_valid = 1'b0;
  logic [WIDTH-1:0] wr_data = '0;
  logic             wr_ready;
  logic             shift_en = 1'b0;
  logic [WIDTH-1:0] sched_in = '0;
  logic [DW-1:0]    data_o;
  logic [CW-1:0]    count;
  logic             full;
  logic             done;

  always #5 CLK = ~CLK;

  sha_wbuf #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SHIFTS(SHIFTS)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .start    (start),
    .wr_valid (wr_valid),
    .wr_data  (wr_data),
    .wr_ready (wr_ready),
    .shift_en (shift_en),
    .sched_in (sched_in),
    .data_o   (data_o),
    .count    (count),
    .full     (full),
    .done     (done)
  );

  typedef struct {
    int            cnt;
    bit            full;
    bit            done;
    bit            rdy;
    logic [DW-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model: bank as a FIFO of words, oldest at the front
  logic [WIDTH-1:0] m_bank[$];
  int               m_mode;   // 0 idle, 1 loading words, 2 running schedule
  int               m_cnt;
  int               m_sh;
  bit               m_done;

  function automatic void m_reset();
    m_bank.delete();
    for (int i = 0; i < DEPTH; i++) m_bank.push_back('0);
    m_mode = 0;
    m_cnt  = 0;
    m_sh   = 0;
    m_done = 1'b0;
  endfunction

  function automatic void m_push(logic [WIDTH-1:0] w);
    void'(m_bank.pop_front());
    m_bank.push_back(w);
  endfunction

  function automatic void m_step(bit st, bit wv, logic [WIDTH-1:0] wd, bit se, logic [WIDTH-1:0] si);
    m_done = 1'b0;
    if (st) begin
`ifdef SHA_WBUF_CLR_EN
      for (int i = 0; i < DEPTH; i++) m_bank[i] = '0;
`endif
      m_mode = 1;
      m_cnt  = 0;
      m_sh   = 0;
    end else if (m_mode == 1 && wv) begin
      m_push(wd);
      m_cnt++;
      if (m_cnt == DEPTH) m_mode = 2;
    end else if (m_mode == 2 && se) begin
      m_push(si);
      m_sh++;
      if (m_sh == SHIFTS) begin
        m_done = 1'b1;
        m_mode = 0;
      end
    end
  endfunction

  function automatic exp_t snapshot();
    exp_t e;
    e.cnt  = m_cnt;
    e.full = (m_mode == 2);
    e.done = m_done;
    e.rdy  = (m_mode == 1);
    for (int i = 0; i < DEPTH; i++) e.data[i*WIDTH +: WIDTH] = m_bank[i];
    return e;
  endfunction

  task automatic cmp_exp(string tag, exp_t e);
    logic [CW-1:0] ec;
    ec = CW'(e.cnt);
    tests++;
    if (count !== ec) begin
      fails++;
      $display("FAIL %s count: got %0d expected %0d at %0t", tag, count, ec, $time);
    end
    tests++;
    if (full !== e.full) begin
      fails++;
      $display("FAIL %s full: got %b expected %b at %0t", tag, full, e.full, $time);
    end
    tests++;
    if (done !== e.done) begin
      fails++;
      $display("FAIL %s done: got %b expected %b at %0t", tag, done, e.done, $time);
    end
    tests++;
    if (wr_ready !== e.rdy) begin
      fails++;
      $display("FAIL %s wr_ready: got %b expected %b at %0t", tag, wr_ready, e.rdy, $time);
    end
    tests++;
    if (data_o !== e.data) begin
      fails++;
      $display("FAIL %s data_o: got %h expected %h at %0t", tag, data_o, e.data, $time);
    end
  endtask

  // Monitor: each edge's registered outputs checked against the queued expectation
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        cmp_exp("cycle", e);
      end
    end
  end

  task automatic cyc(bit r, bit st, bit wv, logic [WIDTH-1:0] wd, bit se, logic [WIDTH-1:0] si);
    @(negedge CLK);
    RST      = r;
    start    = st;
    wr_valid = wv;
    wr_data  = wd;
    shift_en = se;
    sched_in = si;
    if (r) m_reset();
    else m_step(st, wv, wd, se, si);
    exp_q.push_back(snapshot());
  endtask

  task automatic async_reset();
    @(negedge CLK);
    start    = 1'b0;
    wr_valid = 1'b0;
    shift_en = 1'b0;
    RST      = 1'b1;
    #1;
    m_reset();
    cmp_exp("async_rst", snapshot());
    exp_q.push_back(snapshot());
  endtask

  int shifts;

  initial begin
    m_reset();
    #1 RST = 1'b1;
    #1 cmp_exp("reset", snapshot());
    cyc(1, 0, 0, '0, 0, '0);
    cyc(0, 0, 0, '0, 0, '0);

    // Mid-fill asynchronous reset after five words
    cyc(0, 1, 0, '0, 0, '0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, $urandom, 0, '0);
    async_reset();
    cyc(1, 0, 1, $urandom, 1, $urandom);
    cyc(0, 0, 0, '0, 0, '0);

    // Directed fill with 1..16 then 48 shifts of a constant
    cyc(0, 1, 0, '0, 0, '0);
    for (int i = 1; i <= DEPTH; i++) cyc(0, 0, 1, WIDTH'(i), 0, '0);
    for (int i = 0; i < SHIFTS; i++) cyc(0, 0, 0, '0, 1, 32'hA5A5_A5A5);
    for (int i = 0; i < 4; i++) cyc(0, 0, $urandom_range(0, 1), $urandom, $urandom_range(0, 1), $urandom);

    // Start alone: bank kept (or zeroed with the clear option)
    cyc(0, 1, 0, '0, 0, '0);

    // Gapped fill with shift_en held high
    for (int i = 0; i < 2 * DEPTH; i++) cyc(0, 0, (i % 2) == 0, $urandom, 1, $urandom);

    // Gapped run, then start colliding with a shift after ten shifts
    shifts = 0;
    while (shifts < 10) begin
      bit se;
      se = $urandom_range(0, 1);
      cyc(0, 0, $urandom_range(0, 1), $urandom, se, $urandom);
      if (se) shifts++;
    end
    cyc(0, 1, 0, '0, 1, $urandom);
    cyc(0, 0, 0, '0, 0, '0);

    // Fully random traffic with occasional starts
    for (int i = 0; i < 3000; i++)
      cyc(0, $urandom_range(0, 59) == 0, $urandom_range(0, 3) != 0, $urandom,
          $urandom_range(0, 3) != 0, $urandom);

    cyc(0, 0, 0, '0, 0, '0);
    @(posedge CLK);
    #3;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_sha_wbuf
